// File: rtl/ps2_event_receiver.sv
// PS/2 host-side receiver: pin synchronisation, clock glitch filter, 11-bit
// frame deframing, E0/F0 prefix folding and a first-word fall-through event FIFO.
module ps2_event_receiver #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ps2_clock,
    input  logic                          ps2_data,
    output logic [7:0]                    event_code,
    output logic                          event_extended,
    output logic                          event_break,
    output logic                          event_valid,
    input  logic                          event_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_error
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 10;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_s;
    logic          dat_s;
    logic          filt;
    logic          filt_q;
    logic [FW-1:0] fcnt;
    logic          fall_c;

    state_t        state;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic          par_ok;
    logic [TW-1:0] tcnt;
    logic          byte_done;

    logic          ext_pend;
    logic          brk_pend;
    logic          is_prefix_c;
    logic          push_c;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_c;
    logic          full_c;
    logic          wr_c;
    logic [CW-1:0] count_nxt;
    logic [EW-1:0] head;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Two-flop synchronisers for both asynchronous PS/2 pins (idle level high)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clock};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Glitch filter: filtered clock follows only after FILTER_LEN stable cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt   <= 1'b1;
            filt_q <= 1'b1;
            fcnt   <= '0;
        end else begin
            filt_q <= filt;
            if (clk_s != filt) begin
                if (fcnt == FW'(FILTER_LEN - 1)) begin
                    filt <= clk_s;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign fall_c = filt_q & ~filt;

    // Frame FSM with timeout; byte_done and frame_error are one-cycle pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= '0;
            bit_idx     <= '0;
            par_ok      <= 1'b0;
            tcnt        <= '0;
            byte_done   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            byte_done   <= 1'b0;
            frame_error <= 1'b0;
            if (fall_c) begin
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (!dat_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {dat_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_ok <= ^{shift, dat_s};
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (dat_s && par_ok) byte_done   <= 1'b1;
                        else                 frame_error <= 1'b1;
                    end
                endcase
            end else if (state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state       <= IDLE;
                frame_error <= 1'b1;
                tcnt        <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    assign is_prefix_c = (shift == 8'hE0) || (shift == 8'hF0);
    assign push_c      = byte_done & ~is_prefix_c;

    // Prefix flags: set by E0/F0, consumed by the next key byte, dropped on error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_done) begin
            if (shift == 8'hE0) begin
                ext_pend <= 1'b1;
            end else if (shift == 8'hF0) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end else if (frame_error) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end
    end

    assign pop_c  = event_valid & event_ready;
    assign full_c = (fifo_count == CW'(FIFO_DEPTH));
    assign wr_c   = push_c & (~full_c | pop_c);

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        count_nxt = fifo_count;
        if (wr_c && !pop_c)      count_nxt = fifo_count + CW'(1);
        else if (!wr_c && pop_c) count_nxt = fifo_count - CW'(1);
    end

    // Event storage; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (wr_c) mem[wr_ptr] <= {ext_pend, brk_pend, shift};
    end

    // FIFO pointers, occupancy, valid and overflow pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            event_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            overflow    <= push_c & full_c & ~pop_c;
            fifo_count  <= count_nxt;
            event_valid <= (count_nxt != '0);
            if (wr_c)  wr_ptr <= wr_ptr + AW'(1);
            if (pop_c) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    assign head           = event_valid ? mem[rd_ptr] : '0;
    assign event_code     = head[7:0];
    assign event_break    = head[8];
    assign event_extended = head[9];

endmodule

// File: doc/ps2_event_receiver.md
Name: ps2_event_receiver

Overview:
Parametrised PS/2 host-side receiver. It filters and synchronises the raw PS/2 clock and data lines, deframes 11-bit frames, and folds E0/F0 prefix bytes into single make/break key events. Events are buffered in a FIFO and presented on a valid/ready interface. It sits between the PS/2 pins and the game's input controller, replacing the single-byte, unbuffered receiver.

Parameters:
FILTER_LEN, 4, consecutive clock cycles the synchronised ps2_clock must hold a new level before the filtered level follows (>=1)
TIMEOUT_CYCLES, 100000, cycles without a filtered falling edge after which a partial frame is aborted (2 ms at 50 MHz)
FIFO_DEPTH, 8, event FIFO entries; power of two, >=2

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
ps2_clock  input  1  raw PS/2 clock pin, asynchronous
ps2_data  input  1  raw PS/2 data pin, asynchronous
event_code  output  8  scancode of head event; 0 when FIFO empty
event_extended  output  1  head event was preceded by E0
event_break  output  1  head event was preceded by F0 (key release)
event_valid  output  1  FIFO non-empty
event_ready  input  1  consumer accepts head event
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  one-cycle pulse: event dropped because FIFO full
frame_error  output  1  one-cycle pulse: parity, stop-bit or timeout failure

Behaviour:
- Clock: single clock domain on clock. Reset: asynchronous, active-high.
- Reset state: all outputs 0; FIFO empty; frame FSM IDLE; prefix flags clear; synchroniser flops and filtered clock = 1; filter and timeout counters = 0. Asserting reset mid-frame discards the partial frame and all FIFO contents.
- Sync: 2-flop synchroniser on each of ps2_clock and ps2_data.
- Filter: counter increments while synced clock != filtered level and clears otherwise. When it reaches FILTER_LEN, filtered level takes the synced value and the counter clears. Pulses shorter than FILTER_LEN cycles are ignored.
- fall strobe: 1 cycle, filtered 1->0. Data bit = synced ps2_data in the strobe cycle.
- Frame FSM, advancing only on fall:
  - IDLE: data=0 -> DATA with bit index 0; data=1 -> stay in IDLE, no error.
  - DATA: shift bits in LSB first; after bit 7 -> PARITY.
  - PARITY: record ok = XOR(8 data bits, parity bit) == 1 (odd parity) -> STOP.
  - STOP: if stop=1 and ok, byte complete; otherwise frame_error pulse. Return to IDLE in either case.
- Timeout: counter clears on every fall and while in IDLE. In any other state, reaching TIMEOUT_CYCLES -> IDLE, frame_error pulse, counter cleared.
- Prefix decode on byte complete:
  - E0 sets ext_pending; F0 sets brk_pending; neither is pushed.
  - Any other byte pushes {ext_pending, brk_pending, byte} and clears both flags.
  - frame_error of any cause clears both flags.
- Latency: on a pushing byte, the FIFO is written on the clock edge ending the cycle after the stop-bit strobe cycle. event_valid is therefore high 2 cycles after the stop strobe. No bypass when the FIFO is empty.
- FIFO: 10-bit entries, first-word fall-through. Pop when event_valid & event_ready; event_ready is ignored when empty.
  - Push while full without pop: new event dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle at other counts: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- frame_error and overflow may pulse in the same cycle independently.

Test Plan:
1. Frame 0x1C (start 0, bits LSB first, parity 0, stop 1), PS/2 clock ~12.5 kHz, ready=1 -> exactly one event: code=0x1C, ext=0, brk=0; event_valid 2 cycles after stop strobe; fifo_count returns to 0.
2. Bytes F0,1C then E0,F0,75 -> two events: {0x1C, ext=0, brk=1} then {0x75, ext=1, brk=1}; no events for the prefix bytes.
3. 0x1C sent with parity bit 1 -> frame_error one pulse, no event. Then E0 followed by a stop-bit-0 frame, then 0x1C -> frame_error pulse, event {0x1C, ext=0, brk=0} (prefix cleared).
4. TIMEOUT_CYCLES=200: start bit plus 4 data bits, then idle 300 cycles -> frame_error at cycle 200 after the last fall, FSM IDLE. Following full 0x29 frame -> event code=0x29.
5. FIFO_DEPTH=4, ready=0, send 0x15,0x1D,0x24,0x2D,0x2C -> fifo_count=4, one overflow pulse on the fifth. Then ready=1 -> codes 0x15,0x1D,0x24,0x2D in order, one per cycle.
6. FILTER_LEN=4: low glitches of 1-3 cycles on ps2_clock while in IDLE and mid-frame -> no state change or extra bits. Subsequent 0x1C decodes correctly.
